// File: rtl/vida_nave_pkg.sv
// rtl/vida_nave_pkg.sv - shared state encoding and default constants for the ship-lives block
package vida_nave_pkg;

   typedef enum logic [1:0] {
      JOGANDO      = 2'd0,
      INVULNERAVEL = 2'd1,
      FIM          = 2'd2
   } estado_t;

   localparam int VIDAS_INICIAIS_PADRAO = 3;
   localparam int TICK_DIV_PADRAO       = 50000;
   localparam int INVULN_TICKS_PADRAO   = 2000;
   localparam int PISCA_TICKS_PADRAO    = 125;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vida_nave_if.sv
// rtl/vida_nave_if.sv - game-side signals of the ship-lives block, grouped with master/slave views
interface vida_nave_if #(
   parameter int NUM_BOLAS = 4
);
   logic                 pausa;
   logic                 reiniciarJogo;
   logic [NUM_BOLAS-1:0] bateunave;
   logic [NUM_BOLAS-1:0] limpar_bolas;
   logic [1:0]           vidas;
   logic                 invulneravel;
   logic                 nave_visivel;
   logic                 fim_de_jogo;

   modport master (
      output pausa, reiniciarJogo, bateunave,
      input  limpar_bolas, vidas, invulneravel, nave_visivel, fim_de_jogo
   );

   modport slave (
      input  pausa, reiniciarJogo, bateunave,
      output limpar_bolas, vidas, invulneravel, nave_visivel, fim_de_jogo
   );
endinterface

// File: rtl/vida_nave_divisor_tick.sv
// rtl/vida_nave_divisor_tick.sv - game tick strobe: one cycle high every DIV enabled clock cycles
module divisor_tick
   import vida_nave_pkg::*;
#(
   parameter int DIV = TICK_DIV_PADRAO
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = largura(DIV);

   logic [CW-1:0] r_cnt;

   assign o_tick = i_en && !i_clr && (r_cnt == CW'(DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/vida_nave.sv
// rtl/vida_nave.sv - ship lives, post-hit invulnerability with blink, game over and restart
module vida_nave
   import vida_nave_pkg::*;
#(
   parameter int NUM_BOLAS      = 4,
   parameter int VIDAS_INICIAIS = VIDAS_INICIAIS_PADRAO,
   parameter int TICK_DIV       = TICK_DIV_PADRAO,
   parameter int INVULN_TICKS   = INVULN_TICKS_PADRAO,
   parameter int PISCA_TICKS    = PISCA_TICKS_PADRAO
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   vida_nave_if.slave bus
);
   localparam int IW = largura(INVULN_TICKS);
   localparam int PW = largura(PISCA_TICKS);

   estado_t              r_estado;
   logic [1:0]           r_vidas;
   logic [IW-1:0]        r_invuln_cnt;
   logic [PW-1:0]        r_pisca_cnt;
   logic                 r_visivel;
   logic [NUM_BOLAS-1:0] r_limpar;
   logic [NUM_BOLAS-1:0] r_bq;
   logic                 w_tick;
   logic                 w_hit;

   divisor_tick #(.DIV(TICK_DIV)) u_tick (
      .i_clk  (CLOCK_50),
      .i_rst  (reset),
      .i_en   (~bus.pausa),
      .i_clr  (bus.reiniciarJogo),
      .o_tick (w_tick)
   );

   // Several bullets rising together still collapse into a single hit.
   assign w_hit = |(bus.bateunave & ~r_bq);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_estado     <= JOGANDO;
         r_vidas      <= 2'(VIDAS_INICIAIS);
         r_invuln_cnt <= '0;
         r_pisca_cnt  <= '0;
         r_visivel    <= 1'b1;
         r_limpar     <= '0;
         r_bq         <= '0;
      end else if (bus.reiniciarJogo) begin
         r_estado     <= JOGANDO;
         r_vidas      <= 2'(VIDAS_INICIAIS);
         r_invuln_cnt <= '0;
         r_pisca_cnt  <= '0;
         r_visivel    <= 1'b1;
         r_limpar     <= '1;
         r_bq         <= bus.bateunave;
      end else if (bus.pausa) begin
         r_limpar <= '0;
      end else begin
         r_bq     <= bus.bateunave;
         // Masking with the previous pulse keeps each clear to a single cycle.
         r_limpar <= bus.bateunave & ~r_limpar;
         case (r_estado)
            JOGANDO: begin
               if (w_hit) begin
                  r_visivel <= 1'b0;
                  if (r_vidas <= 2'd1) begin
                     r_vidas  <= 2'd0;
                     r_estado <= FIM;
                  end else begin
                     r_vidas      <= r_vidas - 1'b1;
                     r_estado     <= INVULNERAVEL;
                     r_invuln_cnt <= '0;
                     r_pisca_cnt  <= '0;
                  end
               end
            end
            INVULNERAVEL: begin
               if (w_tick) begin
                  if (r_invuln_cnt == IW'(INVULN_TICKS - 1)) begin
                     r_estado     <= JOGANDO;
                     r_visivel    <= 1'b1;
                     r_invuln_cnt <= '0;
                  end else begin
                     r_invuln_cnt <= r_invuln_cnt + 1'b1;
                     if (r_pisca_cnt == PW'(PISCA_TICKS - 1)) begin
                        r_pisca_cnt <= '0;
                        r_visivel   <= ~r_visivel;
                     end else begin
                        r_pisca_cnt <= r_pisca_cnt + 1'b1;
                     end
                  end
               end
            end
            FIM: begin
               r_visivel <= 1'b0;
            end
            default: begin
               r_estado <= JOGANDO;
            end
         endcase
      end
   end

   assign bus.limpar_bolas = r_limpar;
   assign bus.vidas        = r_vidas;
   assign bus.invulneravel = (r_estado == INVULNERAVEL);
   assign bus.nave_visivel = r_visivel;
   assign bus.fim_de_jogo  = (r_estado == FIM);
endmodule

// File: tb/tb_vida_nave.sv
// tb/tb_vida_nave.sv - self-checking bench for vida_nave against a tick/lives reference model
module tb_vida_nave;
   localparam int NB = 4;
   localparam int VI = 3;
   localparam int TD = 4;
   localparam int IT = 8;
   localparam int PS = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   // Reference model state
   int           m_lives;
   int           m_mode;   // 0 playing, 1 invulnerable, 2 game over
   int           m_ph;     // unpaused cycles since reset/restart, modulo TD
   int           m_inv;    // ticks elapsed while invulnerable
   logic [NB-1:0] m_bq;
   logic [NB-1:0] m_limp;

   vida_nave_if #(.NUM_BOLAS(NB)) bus ();

   vida_nave #(
      .NUM_BOLAS(NB), .VIDAS_INICIAIS(VI), .TICK_DIV(TD),
      .INVULN_TICKS(IT), .PISCA_TICKS(PS)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic logic exp_vis();
      if (m_mode == 0) return 1'b1;
      if (m_mode == 1) return ((m_inv / PS) % 2) == 1;
      return 1'b0;
   endfunction

   function automatic logic [NB+4:0] exp_vec();
      return {2'(m_lives), m_mode == 1, exp_vis(), m_mode == 2, m_limp};
   endfunction

   function automatic logic [NB+4:0] dut_vec();
      return {bus.vidas, bus.invulneravel, bus.nave_visivel, bus.fim_de_jogo, bus.limpar_bolas};
   endfunction

   task automatic model_reset();
      m_lives = VI; m_mode = 0; m_ph = 0; m_inv = 0; m_bq = '0; m_limp = '0;
   endtask

   // Advance model and DUT by one clock; bullets drop their flag when cleared.
   task automatic step();
      logic [NB-1:0] b;
      logic tick, hit;
      b = bus.bateunave;
      if (bus.reiniciarJogo) begin
         m_lives = VI; m_mode = 0; m_ph = 0; m_inv = 0; m_limp = '1; m_bq = b;
      end else if (bus.pausa) begin
         m_limp = '0;
      end else begin
         tick = (m_ph == TD - 1);
         m_ph = (m_ph + 1) % TD;
         hit = |(b & ~m_bq);
         m_bq = b;
         m_limp = b & ~m_limp;
         if (m_mode == 0 && hit) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = 2;
            else begin m_mode = 1; m_inv = 0; end
         end else if (m_mode == 1 && tick) begin
            m_inv = m_inv + 1;
            if (m_inv == IT) m_mode = 0;
         end
      end
      @(posedge clk); #1;
      bus.bateunave = bus.bateunave & ~bus.limpar_bolas;
   endtask

   task automatic wait_jogando();
      for (int i = 0; i < 100 && m_mode != 0; i++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pausa = 1'b0; bus.reiniciarJogo = 1'b0; bus.bateunave = '0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (bus.vidas !== 2'd3) $display("FAIL reset_vidas got %0d want 3", bus.vidas); else n_pass++;
      n_total++; if (bus.invulneravel !== 1'b0) $display("FAIL reset_invuln got %b want 0", bus.invulneravel); else n_pass++;
      n_total++; if (bus.nave_visivel !== 1'b1) $display("FAIL reset_visivel got %b want 1", bus.nave_visivel); else n_pass++;
      n_total++; if (bus.fim_de_jogo !== 1'b0) $display("FAIL reset_fim got %b want 0", bus.fim_de_jogo); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b0000) $display("FAIL reset_limpar got %b want 0000", bus.limpar_bolas); else n_pass++;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single_hit();
      int lives_before;
      bus.bateunave = 4'b0010;
      step();
      n_total++; if (bus.vidas !== 2'd2) $display("FAIL hit_vidas got %0d want 2", bus.vidas); else n_pass++;
      n_total++; if (bus.invulneravel !== 1'b1) $display("FAIL hit_invuln got %b want 1", bus.invulneravel); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b0010) $display("FAIL hit_limpar got %b want 0010", bus.limpar_bolas); else n_pass++;
      step();
      n_total++; if (bus.limpar_bolas !== 4'b0000) $display("FAIL hit_limpar_once got %b want 0000", bus.limpar_bolas); else n_pass++;
      // Ignored hit while invulnerable, then ride out the blink window.
      lives_before = m_lives;
      bus.bateunave = 4'b0100;
      step();
      n_total++; if (bus.vidas !== 2'(lives_before)) $display("FAIL inv_hit_vidas got %0d want %0d", bus.vidas, lives_before); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b0100) $display("FAIL inv_hit_limpar got %b want 0100", bus.limpar_bolas); else n_pass++;
      for (int i = 0; i < 40 && bus.invulneravel; i++) begin
         step();
         n_total++;
         if ({bus.invulneravel, bus.nave_visivel} !== {m_mode == 1, exp_vis()})
            $display("FAIL blink cycle %0d got inv=%b vis=%b want inv=%b vis=%b",
                     i, bus.invulneravel, bus.nave_visivel, m_mode == 1, exp_vis());
         else n_pass++;
      end
      n_total++; if (bus.invulneravel !== 1'b0) $display("FAIL inv_timeout got %b want 0", bus.invulneravel); else n_pass++;
      n_total++; if (bus.nave_visivel !== 1'b1) $display("FAIL inv_end_visivel got %b want 1", bus.nave_visivel); else n_pass++;
   endtask

   task automatic test_simultaneous();
      int lives_before;
      wait_jogando();
      lives_before = m_lives;
      bus.bateunave = 4'b1001;
      step();
      n_total++; if (bus.vidas !== 2'(lives_before - 1)) $display("FAIL simul_vidas got %0d want %0d", bus.vidas, lives_before - 1); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b1001) $display("FAIL simul_limpar got %b want 1001", bus.limpar_bolas); else n_pass++;
      step();
      n_total++; if (bus.limpar_bolas !== 4'b0000) $display("FAIL simul_limpar_once got %b want 0000", bus.limpar_bolas); else n_pass++;
   endtask

   task automatic test_game_over();
      bus.reiniciarJogo = 1'b1;
      step();
      bus.reiniciarJogo = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_jogando();
         bus.bateunave = 4'(1 << k);
         step();
         n_total++; if (bus.vidas !== 2'(2 - k)) $display("FAIL over_vidas%0d got %0d want %0d", k, bus.vidas, 2 - k); else n_pass++;
      end
      n_total++; if (bus.fim_de_jogo !== 1'b1) $display("FAIL over_fim got %b want 1", bus.fim_de_jogo); else n_pass++;
      n_total++; if (bus.nave_visivel !== 1'b0) $display("FAIL over_visivel got %b want 0", bus.nave_visivel); else n_pass++;
      step();
      bus.bateunave = 4'b1000;
      step();
      n_total++; if (bus.vidas !== 2'd0) $display("FAIL over_ignore_vidas got %0d want 0", bus.vidas); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b1000) $display("FAIL over_ignore_limpar got %b want 1000", bus.limpar_bolas); else n_pass++;
      bus.reiniciarJogo = 1'b1;
      bus.bateunave = 4'b0001;
      step();
      bus.reiniciarJogo = 1'b0;
      n_total++; if (bus.vidas !== 2'd3) $display("FAIL restart_vidas got %0d want 3", bus.vidas); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b1111) $display("FAIL restart_limpar got %b want 1111", bus.limpar_bolas); else n_pass++;
      n_total++; if (bus.fim_de_jogo !== 1'b0) $display("FAIL restart_fim got %b want 0", bus.fim_de_jogo); else n_pass++;
      step();
      n_total++; if (bus.limpar_bolas !== 4'b0000) $display("FAIL restart_limpar_once got %b want 0000", bus.limpar_bolas); else n_pass++;
   endtask

   task automatic test_pause();
      int lives_before;
      wait_jogando();
      lives_before = m_lives;
      bus.pausa = 1'b1;
      step();
      bus.bateunave = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         step();
         n_total++;
         if ({bus.vidas, bus.invulneravel, bus.limpar_bolas} !== {2'(lives_before), 1'b0, 4'b0000})
            $display("FAIL pause cycle %0d got vidas=%0d inv=%b limpar=%b want vidas=%0d inv=0 limpar=0000",
                     i, bus.vidas, bus.invulneravel, bus.limpar_bolas, lives_before);
         else n_pass++;
      end
      bus.pausa = 1'b0;
      step();
      n_total++; if (bus.vidas !== 2'(lives_before - 1)) $display("FAIL unpause_vidas got %0d want %0d", bus.vidas, lives_before - 1); else n_pass++;
      n_total++; if (bus.limpar_bolas !== 4'b0010) $display("FAIL unpause_limpar got %b want 0010", bus.limpar_bolas); else n_pass++;
      n_total++; if (bus.invulneravel !== 1'b1) $display("FAIL unpause_invuln got %b want 1", bus.invulneravel); else n_pass++;
   endtask

   task automatic test_async_reset();
      repeat (5) step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if (dut_vec() !== {2'd3, 1'b0, 1'b1, 1'b0, 4'b0000})
         $display("FAIL async_reset got %b want %b", dut_vec(), {2'd3, 1'b0, 1'b1, 1'b0, 4'b0000});
      else n_pass++;
      #1;
      rst = 1'b0;
      bus.bateunave = '0;
      model_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         bus.pausa         = ($urandom_range(7) == 0);
         bus.reiniciarJogo = ($urandom_range(63) == 0);
         for (int j = 0; j < NB; j++)
            if ($urandom_range(15) == 0) bus.bateunave[j] = 1'b1;
         step();
         n_total++;
         if (dut_vec() !== exp_vec())
            $display("FAIL random cycle %0d got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      bus.pausa = 1'b0;
      bus.reiniciarJogo = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_simultaneous();
      test_game_over();
      test_pause();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
